// File: rtl/square_renderer_if.sv
// Write/commit bus of the square renderer.
// The master (game logic) loads square coordinates into the shadow table
// and requests a commit. The slave (renderer) reports back whether it can
// accept a write and whether a commit is still waiting for a frame boundary.
interface square_renderer_if #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 6
);
    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_idx;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_en;
    logic               commit;
    logic               commit_pending;

    modport master (
        output wr_valid, wr_idx, wr_x, wr_y, wr_en, commit,
        input  wr_ready, commit_pending
    );

    modport slave (
        input  wr_valid, wr_idx, wr_x, wr_y, wr_en, commit,
        output wr_ready, commit_pending
    );
endinterface

// File: rtl/square_renderer.sv
// Square renderer: draws up to N_SQ axis-aligned squares (slot 0 = head,
// slots 1..N_SQ-1 = body) over a background colour.
// Coordinates are written into a shadow table. A commit copies the whole
// shadow table into the active table on the next frame_start, so a frame
// is never drawn from a half-updated table.
// Pixel path: stage 1 registers the per-slot hit/edge vectors, stage 2
// registers the selected colour, giving two cycles of latency.
module square_renderer #(
    parameter int          N_SQ         = 33,
    parameter int          SQ_SIZE      = 16,
    parameter int          COORD_W      = 10,
    parameter int          IDX_W        = 6,
    parameter logic [11:0] HEAD_COLOR   = 12'h0F0,
    parameter logic [11:0] BODY_COLOR   = 12'h00F,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          OUTLINE      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_start,
    square_renderer_if.slave   wr,
    output logic [11:0]        rgb,
    output logic               rgb_valid
);

    // Square extent in COORD_W+1 bits so a square near the right/bottom
    // limit extends past 2^COORD_W-1 instead of wrapping to 0.
    localparam logic [COORD_W:0] SIZE_EXT = (COORD_W + 1)'(SQ_SIZE);
    localparam logic [COORD_W:0] SIZE_M1  = (COORD_W + 1)'(SQ_SIZE - 1);
    localparam logic [IDX_W:0]   N_SQ_EXT = (IDX_W + 1)'(N_SQ);

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

    slot_t shadow_tbl [N_SQ];
    slot_t active_tbl [N_SQ];

    logic            copy;
    logic            wr_fire;
    logic [N_SQ-1:0] hit_c;
    logic [N_SQ-1:0] edge_c;
    logic [N_SQ-1:0] s1_hit;
    logic [N_SQ-1:0] s1_edge;
    logic            s1_video;
    logic            lowest_edge;
    logic [11:0]     pix_c;

    // Frozen shadow table while a commit waits for its frame boundary.
    assign wr.wr_ready = ~wr.commit_pending;

    // A commit arriving together with frame_start copies immediately.
    assign copy = frame_start & (wr.commit_pending | wr.commit);

    // Out-of-range indices complete the handshake but write nothing.
    assign wr_fire = wr.wr_valid & wr.wr_ready & ({1'b0, wr.wr_idx} < N_SQ_EXT);

    // Commit request tracking: set by commit, cleared by the copy.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            wr.commit_pending <= 1'b0;
        end else if (copy) begin
            wr.commit_pending <= 1'b0;
        end else if (wr.commit) begin
            wr.commit_pending <= 1'b1;
        end
    end

    // Shadow writes and the single-cycle shadow-to-active copy.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the tables are register arrays, not RAM, so they can and
        // must be cleared by the async reset; a RAM macro could not be.
        if (!reset) begin
            for (int i = 0; i < N_SQ; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            if (wr_fire) begin
                shadow_tbl[wr.wr_idx] <= '{en: wr.wr_en, x: wr.wr_x, y: wr.wr_y};
            end
            if (copy) begin
                for (int i = 0; i < N_SQ; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
        end
    end

    // Per-slot hit and perimeter tests against the active table.
    always_comb begin
        // NOTE: defaults first so no path leaves a bit unassigned (no latch).
        hit_c  = '0;
        edge_c = '0;
        for (int i = 0; i < N_SQ; i++) begin
            hit_c[i] = active_tbl[i].en
                && ({1'b0, x} >= {1'b0, active_tbl[i].x})
                && ({1'b0, x} <  ({1'b0, active_tbl[i].x} + SIZE_EXT))
                && ({1'b0, y} >= {1'b0, active_tbl[i].y})
                && ({1'b0, y} <  ({1'b0, active_tbl[i].y} + SIZE_EXT));
            edge_c[i] = (x == active_tbl[i].x)
                || ({1'b0, x} == ({1'b0, active_tbl[i].x} + SIZE_M1))
                || (y == active_tbl[i].y)
                || ({1'b0, y} == ({1'b0, active_tbl[i].y} + SIZE_M1));
        end
    end

    // Stage 1: register hit vector, edge flags and video_on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_hit   <= '0;
            s1_edge  <= '0;
            s1_video <= 1'b0;
        end else begin
            s1_hit   <= hit_c;
            s1_edge  <= edge_c;
            s1_video <= video_on;
        end
    end

    // Colour priority: blanking, head, body (border on its edge), background.
    always_comb begin
        lowest_edge = 1'b0;
        // Descending scan: the last match is the lowest-indexed body slot.
        for (int i = N_SQ - 1; i >= 1; i--) begin
            if (s1_hit[i]) begin
                lowest_edge = s1_edge[i];
            end
        end
        if (!s1_video) begin
            pix_c = 12'h000;
        end else if (s1_hit[0]) begin
            pix_c = HEAD_COLOR;
        end else if (|s1_hit[N_SQ-1:1]) begin
            pix_c = ((OUTLINE != 0) && lowest_edge) ? BORDER_COLOR : BODY_COLOR;
        end else begin
            pix_c = BG_COLOR;
        end
    end

    // Stage 2: register the output pixel and its valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb       <= 12'h000;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= pix_c;
            rgb_valid <= s1_video;
        end
    end

endmodule
